sb_cache_write_port: RTL

SB_CACHE_WRITE_PORT -- requirements
Module: sb_cache_write_port

---
 rtl/sb_cache_write_port.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/sb_cache_write_port.sv
// Store-buffer drain port into a direct-mapped, write-back, write-allocate cache.
// One store is committed at a time; a miss writes back a dirty victim, then fills the line.
module sb_cache_write_port #(
    parameter int DATA_W         = 32,
    parameter int NUM_LINES      = 4,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             CacheWrite,
    input  logic [31:0]                      Address_in,
    input  logic [DATA_W-1:0]                Data_in,
    input  logic                             ByteAddress_in,
    output logic                             CacheReady,
    output logic                             Busy,
    output logic                             MemReq,
    output logic                             MemWE,
    output logic [31:0]                      MemAddr,
    output logic [DATA_W*WORDS_PER_LINE-1:0] MemWData,
    input  logic [DATA_W*WORDS_PER_LINE-1:0] MemRData,
    input  logic                             MemAck
);
    localparam int LINE_W = DATA_W * WORDS_PER_LINE;
    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = $clog2(LANES);
    localparam int WORD_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int OFF_W  = WORD_W + LANE_W;
    localparam int TAG_W  = 32 - IDX_W - OFF_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, FILL} state_t;

    state_t               state_reg, state_next;
    logic [31:0]          req_addr_reg, req_addr_next;
    logic [DATA_W-1:0]    req_data_reg, req_data_next;
    logic                 req_byte_reg, req_byte_next;
    logic                 ready_reg, ready_next;
    logic                 busy_reg, busy_next;
    logic                 mem_req_reg, mem_req_next;
    logic                 mem_we_reg, mem_we_next;
    logic [31:0]          mem_addr_reg, mem_addr_next;
    logic [LINE_W-1:0]    mem_wdata_reg, mem_wdata_next;
    logic [NUM_LINES-1:0] valid_reg, valid_next;
    logic [NUM_LINES-1:0] dirty_reg, dirty_next;

    logic [LINE_W-1:0]    data_mem [NUM_LINES];
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];

    logic [LANE_W-1:0]    req_lane;
    logic [WORD_W-1:0]    req_word;
    logic [IDX_W-1:0]     req_idx;
    logic [TAG_W-1:0]     req_tag;
    logic [LINE_W-1:0]    line_rd;
    logic [LINE_W-1:0]    line_merged;
    logic [LINE_W-1:0]    line_wdata;
    logic [DATA_W-1:0]    line_words [WORDS_PER_LINE];
    logic [DATA_W-1:0]    word_merged;
    logic                 line_we;
    logic                 tag_we;
    logic                 hit;

    assign req_lane = req_addr_reg[LANE_W-1:0];
    assign req_word = req_addr_reg[OFF_W-1:LANE_W];
    assign req_idx  = req_addr_reg[OFF_W+IDX_W-1:OFF_W];
    assign req_tag  = req_addr_reg[31:32-TAG_W];

    assign line_rd = data_mem[req_idx];
    assign hit     = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);

    genvar gi;
    generate
        for (gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
            assign line_words[gi] = line_rd[gi*DATA_W +: DATA_W];
            assign line_merged[gi*DATA_W +: DATA_W] =
                (req_word == WORD_W'(gi)) ? word_merged : line_words[gi];
        end
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            // Byte stores always carry their byte in the low lane of the data.
            assign word_merged[gi*8 +: 8] =
                !req_byte_reg                ? req_data_reg[gi*8 +: 8] :
                (req_lane == LANE_W'(gi))    ? req_data_reg[7:0]       :
                                               line_words[req_word][gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        req_addr_next  = req_addr_reg;
        req_data_next  = req_data_reg;
        req_byte_next  = req_byte_reg;
        ready_next     = 1'b0;
        mem_req_next   = mem_req_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        valid_next     = valid_reg;
        dirty_next     = dirty_reg;
        line_we        = 1'b0;
        line_wdata     = line_merged;
        tag_we         = 1'b0;

        case (state_reg)
            IDLE: begin
                // The initiator still holds CacheWrite on the edge that sees CacheReady.
                if (CacheWrite && !ready_reg) begin
                    req_addr_next = Address_in;
                    req_data_next = Data_in;
                    req_byte_next = ByteAddress_in;
                    state_next    = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    line_we             = 1'b1;
                    dirty_next[req_idx] = 1'b1;
                    ready_next          = 1'b1;
                    state_next          = IDLE;
                end else if (valid_reg[req_idx] && dirty_reg[req_idx]) begin
                    state_next     = WRITEBACK;
                    mem_req_next   = 1'b1;
                    mem_we_next    = 1'b1;
                    mem_addr_next  = {tag_mem[req_idx], req_idx, {OFF_W{1'b0}}};
                    mem_wdata_next = line_rd;
                end else begin
                    state_next    = FILL;
                    mem_req_next  = 1'b1;
                    mem_we_next   = 1'b0;
                    mem_addr_next = {req_tag, req_idx, {OFF_W{1'b0}}};
                end
            end
            WRITEBACK: begin
                if (mem_req_reg && MemAck) begin
                    dirty_next[req_idx] = 1'b0;
                    mem_req_next        = 1'b0;
                    mem_we_next         = 1'b0;
                    mem_addr_next       = {req_tag, req_idx, {OFF_W{1'b0}}};
                    state_next          = FILL;
                end
            end
            FILL: begin
                // Arriving from a writeback, the request stays low for one cycle first.
                if (!mem_req_reg) begin
                    mem_req_next = 1'b1;
                end else if (MemAck) begin
                    line_we             = 1'b1;
                    line_wdata          = MemRData;
                    tag_we              = 1'b1;
                    valid_next[req_idx] = 1'b1;
                    dirty_next[req_idx] = 1'b0;
                    mem_req_next        = 1'b0;
                    state_next          = LOOKUP;
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            req_addr_reg  <= '0;
            req_data_reg  <= '0;
            req_byte_reg  <= 1'b0;
            ready_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            valid_reg     <= '0;
            dirty_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            req_addr_reg  <= req_addr_next;
            req_data_reg  <= req_data_next;
            req_byte_reg  <= req_byte_next;
            ready_reg     <= ready_next;
            busy_reg      <= busy_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            valid_reg     <= valid_next;
            dirty_reg     <= dirty_next;
        end
    end

    // Line data and tags are only meaningful under a set valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_mem[req_idx] <= line_wdata;
        end
        if (tag_we) begin
            tag_mem[req_idx] <= req_tag;
        end
    end

    assign CacheReady = ready_reg;
    assign Busy       = busy_reg;
    assign MemReq     = mem_req_reg;
    assign MemWE      = mem_we_reg;
    assign MemAddr    = mem_addr_reg;
    assign MemWData   = mem_wdata_reg;

endmodule
